// File: rtl/ysyx_22050019_pkg.sv
// Shared definitions for the ysyx_22050019 execute stage: alu_sel encodings
// (also used by the decoder and ID/EX), mul/div FSM states and decode helpers.
package ysyx_22050019_pkg;

    localparam int ALU_W = 5;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SRL    = 5'd3,
        ALU_SRA    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_XOR    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_ADDW   = 5'd10,
        ALU_SUBW   = 5'd11,
        ALU_SLLW   = 5'd12,
        ALU_SRLW   = 5'd13,
        ALU_SRAW   = 5'd14,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_MULW   = 5'd20,
        ALU_DIV    = 5'd21,
        ALU_DIVU   = 5'd22,
        ALU_REM    = 5'd23,
        ALU_REMU   = 5'd24,
        ALU_DIVW   = 5'd25,
        ALU_DIVUW  = 5'd26,
        ALU_REMW   = 5'd27,
        ALU_REMUW  = 5'd28
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } muldiv_state_e;

    function automatic logic is_muldiv(input logic [ALU_W-1:0] sel);
        return (sel >= ALU_MUL) && (sel <= ALU_REMUW);
    endfunction

    function automatic logic is_div(input logic [ALU_W-1:0] sel);
        return (sel >= ALU_DIV) && (sel <= ALU_REMUW);
    endfunction

    function automatic logic is_rem(input logic [ALU_W-1:0] sel);
        return (sel == ALU_REM) || (sel == ALU_REMU) || (sel == ALU_REMW) || (sel == ALU_REMUW);
    endfunction

    function automatic logic is_word(input logic [ALU_W-1:0] sel);
        return ((sel >= ALU_ADDW) && (sel <= ALU_SRAW)) || (sel == ALU_MULW) ||
               ((sel >= ALU_DIVW) && (sel <= ALU_REMUW));
    endfunction

    // MULHSU treats op1 as signed and op2 as unsigned.
    function automatic logic op1_signed(input logic [ALU_W-1:0] sel);
        return (sel == ALU_MUL) || (sel == ALU_MULH) || (sel == ALU_MULHSU) || (sel == ALU_MULW) ||
               (sel == ALU_DIV) || (sel == ALU_REM) || (sel == ALU_DIVW) || (sel == ALU_REMW);
    endfunction

    function automatic logic op2_signed(input logic [ALU_W-1:0] sel);
        return op1_signed(sel) && (sel != ALU_MULHSU);
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050019_exu_muldiv.sv
// Iterative RV64M engine: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle. Only built when YSYX_22050019_MULDIV_EN is defined.
`ifdef YSYX_22050019_MULDIV_EN
module ysyx_22050019_muldiv
    import ysyx_22050019_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [ALU_W-1:0] sel_i,
    input  logic [63:0]      op1_i,
    input  logic [63:0]      op2_i,
    output logic             idle_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [63:0]      result_o
);

    muldiv_state_e    state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [ALU_W-1:0] sel_q, sel_d;
    logic             word_q, word_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [127:0]     mcand_q, mcand_d;
    logic [63:0]      mplier_q, mplier_d;
    logic [127:0]     acc_q, acc_d;
    logic [63:0]      quo_q, quo_d;
    logic [63:0]      rem_q, rem_d;
    logic [63:0]      dvsr_q, dvsr_d;
    logic [63:0]      result_q, result_d;

    logic        word_in, s1, s2;
    logic [63:0] x1, x2, m1, m2, ovf_min;
    logic [5:0]  last_cnt;
    logic [64:0] div_shift, div_trial;
    logic [127:0] prod_fix;
    logic [63:0] div_pick;

    // Operands are first extended to 64 bits per width/signedness, then made magnitudes.
    assign word_in  = is_word(sel_i);
    assign x1       = word_in ? (op1_signed(sel_i) ? sext32(op1_i[31:0]) : {32'd0, op1_i[31:0]}) : op1_i;
    assign x2       = word_in ? (op2_signed(sel_i) ? sext32(op2_i[31:0]) : {32'd0, op2_i[31:0]}) : op2_i;
    assign s1       = op1_signed(sel_i) & x1[63];
    assign s2       = op2_signed(sel_i) & x2[63];
    assign m1       = s1 ? -x1 : x1;
    assign m2       = s2 ? -x2 : x2;
    assign ovf_min  = word_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign last_cnt = word_q ? 6'd31 : 6'd63;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        word_d    = word_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        result_d  = result_q;
        prod_fix  = '0;
        div_pick  = '0;
        div_shift = {rem_q, quo_q[63]};
        div_trial = div_shift - {1'b0, dvsr_q};

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sel_d  = sel_i;
                    word_d = word_in;
                    cnt_d  = '0;
                    neg_d  = s1 ^ s2;
                    rneg_d = s1;
                    if (is_div(sel_i)) begin
                        if (x2 == 64'd0) begin
                            result_d = is_rem(sel_i) ? (word_in ? sext32(op1_i[31:0]) : op1_i)
                                                     : {64{1'b1}};
                            state_d  = ST_DONE;
                        end else if (op1_signed(sel_i) && (x1 == ovf_min) && (x2 == {64{1'b1}})) begin
                            result_d = is_rem(sel_i) ? 64'd0 : x1;
                            state_d  = ST_DONE;
                        end else begin
                            // W dividends sit in the top half so the MSB-first walk is uniform.
                            quo_d   = word_in ? {m1[31:0], 32'd0} : m1;
                            rem_d   = '0;
                            dvsr_d  = m2;
                            state_d = ST_DIV;
                        end
                    end else begin
                        mcand_d  = {64'd0, m1};
                        mplier_d = m2;
                        acc_d    = '0;
                        state_d  = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == last_cnt) begin
                    prod_fix = neg_q ? -acc_d : acc_d;
                    if (sel_q == ALU_MUL)       result_d = prod_fix[63:0];
                    else if (sel_q == ALU_MULW) result_d = sext32(prod_fix[31:0]);
                    else                        result_d = prod_fix[127:64];
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                // A clear borrow bit means the divisor fits: keep the difference, quotient bit 1.
                if (!div_trial[64]) begin
                    rem_d = div_trial[63:0];
                    quo_d = {quo_q[62:0], 1'b1};
                end else begin
                    rem_d = div_shift[63:0];
                    quo_d = {quo_q[62:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == last_cnt) begin
                    div_pick = is_rem(sel_q) ? (rneg_q ? -rem_d : rem_d) : (neg_q ? -quo_d : quo_d);
                    result_d = word_q ? sext32(div_pick[31:0]) : div_pick;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
        end
    end

    assign idle_o   = (state_q == ST_IDLE);
    assign busy_o   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule
`endif

// File: rtl/ysyx_22050019_exu.sv
// Execute stage: combinational RV64I ALU plus optional iterative RV64M engine.
// The M engine is built only when YSYX_22050019_MULDIV_EN is defined.
module ysyx_22050019_exu
    import ysyx_22050019_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [63:0]      op1_i,
    input  logic [63:0]      op2_i,
    input  logic [ALU_W-1:0] alu_sel_i,
    input  logic             flush_i,
    output logic [63:0]      result_o,
    output logic             result_valid_o,
    output logic             stall_o
);

    logic [5:0]  shamt;
    logic [4:0]  shamt_w;
    logic [63:0] add_res, sub_res, alu_res;

    assign shamt   = op2_i[5:0];
    assign shamt_w = op2_i[4:0];
    assign add_res = op1_i + op2_i;
    assign sub_res = op1_i - op2_i;

    always_comb begin
        alu_res = '0;
        case (alu_sel_i)
            ALU_ADD:  alu_res = add_res;
            ALU_SUB:  alu_res = sub_res;
            ALU_SLL:  alu_res = op1_i << shamt;
            ALU_SRL:  alu_res = op1_i >> shamt;
            ALU_SRA:  alu_res = $signed(op1_i) >>> shamt;
            ALU_SLT:  alu_res = {63'd0, $signed(op1_i) < $signed(op2_i)};
            ALU_SLTU: alu_res = {63'd0, op1_i < op2_i};
            ALU_XOR:  alu_res = op1_i ^ op2_i;
            ALU_OR:   alu_res = op1_i | op2_i;
            ALU_AND:  alu_res = op1_i & op2_i;
            ALU_ADDW: alu_res = sext32(add_res[31:0]);
            ALU_SUBW: alu_res = sext32(sub_res[31:0]);
            ALU_SLLW: alu_res = sext32(op1_i[31:0] << shamt_w);
            ALU_SRLW: alu_res = sext32(op1_i[31:0] >> shamt_w);
            ALU_SRAW: alu_res = sext32($signed(op1_i[31:0]) >>> shamt_w);
            default:  alu_res = '0;
        endcase
    end

`ifdef YSYX_22050019_MULDIV_EN
    logic        md_start, md_idle, md_busy, md_done;
    logic [63:0] md_result;

    // Launch only from IDLE, so the DONE cycle never re-issues the op still held in ID/EX.
    assign md_start = valid_i && is_muldiv(alu_sel_i) && md_idle && !flush_i;

    ysyx_22050019_muldiv u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .flush_i  (flush_i),
        .sel_i    (alu_sel_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .idle_o   (md_idle),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    always_comb begin
        result_o       = '0;
        result_valid_o = 1'b0;
        stall_o        = 1'b0;
        if (!flush_i) begin
            if (md_done) begin
                result_o       = md_result;
                result_valid_o = 1'b1;
            end else if (md_busy) begin
                stall_o = 1'b1;
            end else if (valid_i) begin
                if (is_muldiv(alu_sel_i)) begin
                    stall_o = 1'b1;
                end else begin
                    result_o       = alu_res;
                    result_valid_o = 1'b1;
                end
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, flush_i};

    always_comb begin
        result_o       = '0;
        result_valid_o = valid_i;
        stall_o        = 1'b0;
        if (valid_i && !is_muldiv(alu_sel_i)) result_o = alu_res;
    end
`endif

endmodule

// File: tb/tb_ysyx_22050019_exu.sv
// Directed self-checking bench for ysyx_22050019_exu; M-engine scenarios run
// only when YSYX_22050019_MULDIV_EN is defined, otherwise the stub behaviour is checked.
module tb_ysyx_22050019_exu;
    import ysyx_22050019_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_i;
    logic [63:0]      op1_i, op2_i;
    logic [ALU_W-1:0] alu_sel_i;
    logic             flush_i;
    logic [63:0]      result_o;
    logic             result_valid_o;
    logic             stall_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_22050019_exu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .op1_i          (op1_i),
        .op2_i          (op2_i),
        .alu_sel_i      (alu_sel_i),
        .flush_i        (flush_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .stall_o        (stall_o)
    );

    typedef struct {
        alu_sel_e    sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } alu_vec_t;

    task automatic test_reset;
        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        op1_i = '0; op2_i = '0; alu_sel_i = ALU_ADD;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
        checks++;
        if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid_o); end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        $display("reset: result=%h valid=%b stall=%b", result_o, result_valid_o, stall_o);
    endtask

    task automatic test_alu;
        alu_vec_t v [16];
        v[0]  = '{ALU_ADDW, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};
        v[1]  = '{ALU_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
        v[2]  = '{ALU_SUB,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
        v[3]  = '{ALU_SLL,  64'd1, 64'h43, 64'd8};
        v[4]  = '{ALU_SRL,  64'h8000_0000_0000_0000, 64'd63, 64'd1};
        v[5]  = '{ALU_SRA,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
        v[6]  = '{ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
        v[7]  = '{ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
        v[8]  = '{ALU_XOR,  64'hF0, 64'hFF, 64'h0F};
        v[9]  = '{ALU_OR,   64'hF0, 64'h0F, 64'hFF};
        v[10] = '{ALU_AND,  64'hF0, 64'h3C, 64'h30};
        v[11] = '{ALU_SUBW, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        v[12] = '{ALU_SLLW, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000};
        v[13] = '{ALU_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'd1};
        v[14] = '{ALU_SRAW, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000};
        v[15] = '{ALU_ADD,  64'h1234, 64'h1111, 64'h2345};
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            valid_i = 1'b1; alu_sel_i = v[i].sel; op1_i = v[i].a; op2_i = v[i].b; flush_i = 1'b0;
            @(negedge clk);
            checks++;
            if (result_o !== v[i].exp || result_valid_o !== 1'b1 || stall_o !== 1'b0) begin
                errors++;
                $display("FAIL alu[%0d] sel=%0d: result=%h valid=%b stall=%b, expected %h valid=1 stall=0",
                         i, v[i].sel, result_o, result_valid_o, stall_o, v[i].exp);
            end
            $display("alu[%0d] sel=%0d a=%h b=%h -> %h", i, v[i].sel, v[i].a, v[i].b, result_o);
        end
    endtask

    task automatic test_idle;
        @(posedge clk); #1;
        valid_i = 1'b0; alu_sel_i = ALU_ADD; op1_i = 64'd5; op2_i = 64'd6;
        @(negedge clk);
        checks++;
        if (result_o !== 64'd0 || result_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: result=%h valid=%b stall=%b, expected 0/0/0", result_o, result_valid_o, stall_o);
        end
        $display("idle: result=%h valid=%b stall=%b", result_o, result_valid_o, stall_o);
    endtask

`ifdef YSYX_22050019_MULDIV_EN
    // Issues one M op and walks it to DONE (bounded); leaves the bench at the DONE negedge.
    task automatic run_md(input logic [ALU_W-1:0] sel, input logic [63:0] a, input logic [63:0] b,
                          output int stalls, output int early, output logic [63:0] res, output logic vld);
        @(posedge clk); #1;
        valid_i = 1'b1; alu_sel_i = sel; op1_i = a; op2_i = b; flush_i = 1'b0;
        stalls = 0; early = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
            if (result_valid_o) early++;
        end
        res = result_o; vld = result_valid_o;
        $display("md sel=%0d a=%h b=%h -> stalls=%0d result=%h valid=%b", sel, a, b, stalls, res, vld);
    endtask

    task automatic test_mul;
        int st, ea; logic [63:0] r; logic vl;
        run_md(ALU_MULHU, '1, '1, st, ea, r, vl);
        checks++;
        if (st !== 65 || ea !== 0) begin errors++; $display("FAIL mulhu_stall: stalls=%0d early=%0d expected 65/0", st, ea); end
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE || vl !== 1'b1) begin
            errors++; $display("FAIL mulhu_result: got %h valid=%b expected fffffffffffffffe valid=1", r, vl);
        end
        @(posedge clk); #1 valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (result_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL mulhu_one_valid: valid=%b stall=%b after DONE expected 0/0", result_valid_o, stall_o);
        end
        run_md(ALU_MULHSU, '1, '1, st, ea, r, vl);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || vl !== 1'b1) begin
            errors++; $display("FAIL mulhsu_result: got %h valid=%b expected ffffffffffffffff", r, vl);
        end
        run_md(ALU_MULH, '1, '1, st, ea, r, vl);
        checks++;
        if (r !== 64'd0 || vl !== 1'b1) begin errors++; $display("FAIL mulh_result: got %h valid=%b expected 0", r, vl); end
        run_md(ALU_MULW, 64'h7FFF_FFFF, 64'd2, st, ea, r, vl);
        checks++;
        if (st !== 33 || r !== 64'hFFFF_FFFF_FFFF_FFFE || vl !== 1'b1) begin
            errors++; $display("FAIL mulw: stalls=%0d result=%h expected 33 fffffffffffffffe", st, r);
        end
    endtask

    task automatic test_div;
        int st, ea; logic [63:0] r; logic vl;
        run_md(ALU_DIV, 64'h8000_0000_0000_0000, '1, st, ea, r, vl);
        checks++;
        if (st !== 1 || r !== 64'h8000_0000_0000_0000 || vl !== 1'b1) begin
            errors++; $display("FAIL div_overflow: stalls=%0d result=%h expected 1 8000000000000000", st, r);
        end
        run_md(ALU_REMU, 64'd5, 64'd0, st, ea, r, vl);
        checks++;
        if (st !== 1 || r !== 64'd5 || vl !== 1'b1) begin
            errors++; $display("FAIL remu_by_zero: stalls=%0d result=%h expected 1 5", st, r);
        end
        run_md(ALU_DIVUW, 64'd5, 64'h1_0000_0000, st, ea, r, vl);
        checks++;
        if (st !== 1 || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL divuw_by_zero: stalls=%0d result=%h expected 1 ffffffffffffffff", st, r);
        end
        run_md(ALU_DIVW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, st, ea, r, vl);
        checks++;
        if (st !== 33 || r !== 64'hFFFF_FFFF_FFFF_FFFD || vl !== 1'b1) begin
            errors++; $display("FAIL divw: stalls=%0d result=%h expected 33 fffffffffffffffd", st, r);
        end
        run_md(ALU_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, st, ea, r, vl);
        checks++;
        if (st !== 33 || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL remw: stalls=%0d result=%h expected 33 ffffffffffffffff", st, r);
        end
        run_md(ALU_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, st, ea, r, vl);
        checks++;
        if (st !== 65 || r !== 64'hFFFF_FFFF_FFFF_FFF2) begin
            errors++; $display("FAIL div64: stalls=%0d result=%h expected 65 fffffffffffffff2", st, r);
        end
        run_md(ALU_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, st, ea, r, vl);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL rem64: got %h expected fffffffffffffffe", r); end
        @(posedge clk); #1 valid_i = 1'b0;
    endtask

    task automatic test_flush;
        int spur;
        @(posedge clk); #1;
        valid_i = 1'b1; alu_sel_i = ALU_DIV; op1_i = 64'd100; op2_i = 64'd7; flush_i = 1'b0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL flush_busy_before: stall=%b expected 1", stall_o); end
        @(posedge clk); #1 flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0 || result_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_cycle: stall=%b valid=%b expected 0/0", stall_o, result_valid_o);
        end
        @(posedge clk); #1 flush_i = 1'b0; valid_i = 1'b0;
        spur = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (result_valid_o || stall_o) spur++;
        end
        checks++;
        if (spur !== 0) begin errors++; $display("FAIL flush_no_result: %0d active cycles expected 0", spur); end
        @(posedge clk); #1;
        valid_i = 1'b1; alu_sel_i = ALU_ADD; op1_i = 64'd2; op2_i = 64'd3;
        @(negedge clk);
        checks++;
        if (result_o !== 64'd5 || result_valid_o !== 1'b1) begin
            errors++; $display("FAIL flush_then_alu: result=%h valid=%b expected 5/1", result_o, result_valid_o);
        end
        $display("flush: spurious=%0d post-flush add=%h", spur, result_o);
    endtask

    task automatic test_reset_mid;
        int spur;
        @(posedge clk); #1;
        valid_i = 1'b1; alu_sel_i = ALU_MUL; op1_i = 64'd3; op2_i = 64'd4;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0; valid_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (result_o !== 64'd0 || result_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid: result=%h valid=%b stall=%b expected 0/0/0", result_o, result_valid_o, stall_o);
        end
        spur = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (result_valid_o || stall_o) spur++;
        end
        checks++;
        if (spur !== 0) begin errors++; $display("FAIL reset_mid_no_result: %0d active cycles expected 0", spur); end
        $display("reset mid-mul: spurious=%0d", spur);
    endtask

    task automatic test_back_to_back;
        int st, ea; logic [63:0] r; logic vl;
        run_md(ALU_MUL, 64'd3, 64'd4, st, ea, r, vl);
        checks++;
        if (st !== 65 || ea !== 0 || r !== 64'd12 || vl !== 1'b1) begin
            errors++; $display("FAIL b2b_first: stalls=%0d early=%0d result=%h valid=%b expected 65/0/c/1", st, ea, r, vl);
        end
        run_md(ALU_MUL, 64'd5, 64'd6, st, ea, r, vl);
        checks++;
        if (st !== 65 || ea !== 0 || r !== 64'd30 || vl !== 1'b1) begin
            errors++; $display("FAIL b2b_second: stalls=%0d early=%0d result=%h valid=%b expected 65/0/1e/1", st, ea, r, vl);
        end
        @(posedge clk); #1 valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (result_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL b2b_after: valid=%b stall=%b expected 0/0", result_valid_o, stall_o);
        end
    endtask
`else
    task automatic test_muldiv_off;
        @(posedge clk); #1;
        valid_i = 1'b1; alu_sel_i = ALU_MUL; op1_i = 64'd3; op2_i = 64'd4; flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (result_o !== 64'd0 || result_valid_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++; $display("FAIL mul_off: result=%h valid=%b stall=%b expected 0/1/0", result_o, result_valid_o, stall_o);
        end
        @(posedge clk); #1;
        alu_sel_i = ALU_DIVW; op1_i = 64'hFFFF_FFFF_FFFF_FFF9; op2_i = 64'd2;
        @(negedge clk);
        checks++;
        if (result_o !== 64'd0 || result_valid_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++; $display("FAIL divw_off: result=%h valid=%b stall=%b expected 0/1/0", result_o, result_valid_o, stall_o);
        end
        @(posedge clk); #1;
        alu_sel_i = ALU_ADD; op1_i = 64'd2; op2_i = 64'd3; flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (result_o !== 64'd5 || result_valid_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++; $display("FAIL flush_ignored: result=%h valid=%b stall=%b expected 5/1/0", result_o, result_valid_o, stall_o);
        end
        @(posedge clk); #1 flush_i = 1'b0; valid_i = 1'b0;
        $display("muldiv disabled: stub checks done");
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_idle();
`ifdef YSYX_22050019_MULDIV_EN
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_back_to_back();
`else
        test_muldiv_off();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_exu.md
# ysyx_22050019_exu

Execute stage of the ysyx_22050019 RV64 pipeline, directly downstream of the ID/EX register and upstream of EX/MEM. It computes single-cycle integer ALU results (RV64I, including W variants) and runs RV64M multiply/divide on an iterative engine. While a multi-cycle operation is in flight it stalls the front end so that ID/EX holds its operands.

## Interface
- ALU_W, 5: width of alu_sel_i (operation encodings defined in the package).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- valid_i  in  1  ID/EX holds a live instruction.
- op1_i  in  64  operand 1.
- op2_i  in  64  operand 2.
- alu_sel_i  in  ALU_W  operation select.
- flush_i  in  1  kills the in-flight mul/div (trap or redirect).
- result_o  out  64  execute result, to EX/MEM.
- result_valid_o  out  1  result_o is valid this cycle; EX/MEM may capture it.
- stall_o  out  1  freezes PC, IF/ID and ID/EX.

## Operation
- ALU ops: ADD SUB SLL SRL SRA SLT SLTU XOR OR AND ADDW SUBW SLLW SRLW SRAW.
  - Purely combinational.
  - result_valid_o = valid_i.
  - stall_o = 0.
- Shift amounts: op2[5:0]; W ops use op2[4:0].
- W results: low 32 bits, sign-extended to 64.
- M ops: MUL MULH MULHSU MULHU MULW DIV DIVU REM REMU DIVW DIVUW REMW REMUW.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + valid_i + M op: latch operands and op, go to MUL or DIV, stall_o = 1.
  - MUL/DIV: one iteration per cycle; counter counts from 0 to N-1, then go to DONE. stall_o = 1.
  - N = 64 for 64-bit ops, N = 32 for W ops.
  - DONE: result_o = result register, result_valid_o = 1, stall_o = 0; next state IDLE.
  - The DONE cycle never re-launches the operation still held in ID/EX.
- Multiply: operands converted to magnitudes per signedness (MULHSU: op1 signed, op2 unsigned), unsigned shift-add into a 128-bit product, negated if the signs differ.
  - MUL returns product[63:0].
  - MULH* return product[127:64].
  - MULW returns product[31:0], sign-extended.
- Divide: restoring division on magnitudes.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
- Divide special cases, resolved in IDLE with a jump straight to DONE:
  - Divide by zero: quotient = all ones (for W ops: 32 ones, sign-extended), remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- flush_i: has priority over everything else. In any state it forces IDLE next cycle. In the flush cycle result_valid_o = 0 and stall_o = 0.
- valid_i low in IDLE: result_valid_o = 0, stall_o = 0, result_o = 0.

## Timing
- Reset values (next edge with rst_n = 0): state IDLE, counter 0, result register 0, latched operands 0. result_o = 0, result_valid_o = 0, stall_o = 0 while valid_i = 0.
- Reset mid-operation: the operation is dropped; no result is produced.
- ALU op: zero-latency combinational result in the issue cycle.
- Mul/div: issue cycle + N iteration cycles + DONE cycle, all in EX.
  - 64-bit: 66 cycles.
  - W ops: 34 cycles.
  - Divide special case: 2 cycles.
- stall_o is high from the issue cycle through the last iteration cycle and low in DONE. ID/EX therefore advances at the end of DONE, in the same edge where EX/MEM captures the result.
- Back-to-back M ops: the second one issues in the IDLE cycle that immediately follows DONE.

## Configuration
- YSYX_22050019_MULDIV_EN defined: the full M-extension engine and FSM are built.
- YSYX_22050019_MULDIV_EN undefined:
  - No FSM and no sub-module.
  - M ops return result_o = 0 with result_valid_o = valid_i.
  - stall_o is tied to 0 and flush_i is ignored.

## Structure
- Package ysyx_22050019_pkg holds:
  - ALU_W.
  - The alu_sel encodings, shared with the decoder and ID/EX.
  - The FSM state enum.
  - Helper predicates is_muldiv, is_div, is_word.
- Sub-module ysyx_22050019_muldiv holds:
  - The iterative engine: FSM, counter, operand/partial registers, sign fix-up.
  - Its handshake: start, flush, done, result.
- The top level holds the combinational ALU and the output mux.

## Test plan
- ADDW, op1 = 0x7FFFFFFF, op2 = 1 -> result_o = 0xFFFFFFFF80000000 in the same cycle, stall_o = 0.
- MULHU, op1 = op2 = 0xFFFFFFFFFFFFFFFF -> stall_o high for 65 cycles, then DONE with result_o = 0xFFFFFFFFFFFFFFFE and result_valid_o = 1 for exactly one cycle.
- DIV, op1 = 0x8000000000000000, op2 = -1 -> DONE 1 cycle after issue, result_o = 0x8000000000000000. REMU by 0, op1 = 5 -> result_o = 5.
- DIVW, op1 = -7, op2 = 2 -> result_o = 0xFFFFFFFFFFFFFFFD after 34 cycles. REMW with the same operands -> 0xFFFFFFFFFFFFFFFF.
- flush_i at iteration 10 of a DIV -> next cycle IDLE, no result_valid_o, stall_o = 0. rst_n low mid-MUL -> all outputs 0 next cycle.
- Back-to-back MUL 3*4 then MUL 5*6 -> results 12 then 30, each with exactly one valid cycle and no spurious re-issue during DONE.
